// File: rtl/asc_pkg.sv
// Shared encodings for the serial add/subtract/compare block.
package asc_pkg;

    // Operation encodings carried on the op port
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_CMP = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/serial_bit_cell.sv
// One-bit combinational step: add, subtract or compare one bit pair.
module serial_bit_cell
    import asc_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cb,
    input  logic [1:0] op,
    input  logic       agtb_in,
    input  logic       bgta_in,
    output logic       r,
    output logic       cb_out,
    output logic       agtb_out,
    output logic       bgta_out
);

    // Later (more significant) differing bits override the running compare state
    always_comb begin
        r        = 1'b0;
        cb_out   = 1'b0;
        agtb_out = agtb_in;
        bgta_out = bgta_in;
        case (op)
            OP_ADD: begin
                r      = a ^ b ^ cb;
                cb_out = (a & b) | (a & cb) | (b & cb);
            end
            OP_SUB: begin
                r      = a ^ b ^ cb;
                cb_out = (~a & b) | (~(a ^ b) & cb);
            end
            OP_CMP: begin
                if (a != b) begin
                    agtb_out = a;
                    bgta_out = b;
                end
            end
            default: begin
                agtb_out = 1'b0;
                bgta_out = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/serial_add_sub_comp.sv
// Bit-serial unsigned add / subtract / compare, LSB first, N cycles per command.
module serial_add_sub_comp
    import asc_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cbin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         flag,
    output logic         aisbig,
    output logic         bisbig,
    output logic         equal
);

    localparam int unsigned CW = $clog2(N) + 1;

    state_e          state;
    logic [1:0]      op_q;
    logic [N-1:0]    a_sh;
    logic [N-1:0]    b_sh;
    logic [N-1:0]    acc_sh;
    logic            cb_q;
    logic            agtb_q;
    logic            bgta_q;
    logic [CW-1:0]   cnt;

    logic            r_bit;
    logic            cb_nxt;
    logic            agtb_nxt;
    logic            bgta_nxt;
    logic            last_bit;

    serial_bit_cell u_cell (
        .a        (a_sh[0]),
        .b        (b_sh[0]),
        .cb       (cb_q),
        .op       (op_q),
        .agtb_in  (agtb_q),
        .bgta_in  (bgta_q),
        .r        (r_bit),
        .cb_out   (cb_nxt),
        .agtb_out (agtb_nxt),
        .bgta_out (bgta_nxt)
    );

    assign last_bit = (cnt == CW'(N - 1));

    // Controller, datapath shift registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            op_q      <= 2'b00;
            a_sh      <= '0;
            b_sh      <= '0;
            acc_sh    <= '0;
            cb_q      <= 1'b0;
            agtb_q    <= 1'b0;
            bgta_q    <= 1'b0;
            cnt       <= '0;
            result    <= '0;
            flag      <= 1'b0;
            aisbig    <= 1'b0;
            bisbig    <= 1'b0;
            equal     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        op_q     <= op;
                        a_sh     <= a;
                        b_sh     <= b;
                        cb_q     <= cbin;
                        agtb_q   <= 1'b0;
                        bgta_q   <= 1'b0;
                        acc_sh   <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    acc_sh <= {r_bit, acc_sh[N-1:1]};
                    cb_q   <= cb_nxt;
                    agtb_q <= agtb_nxt;
                    bgta_q <= bgta_nxt;
                    cnt    <= cnt + CW'(1);
                    if (last_bit) begin
                        // Cell already yields zero result/flag for compare and reserved
                        result    <= {r_bit, acc_sh[N-1:1]};
                        flag      <= cb_nxt;
                        aisbig    <= (op_q == OP_CMP) && agtb_nxt;
                        bisbig    <= (op_q == OP_CMP) && bgta_nxt;
                        equal     <= (op_q == OP_CMP) && !(agtb_nxt || bgta_nxt);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_sub_comp.sv
// Scoreboard bench for serial_add_sub_comp with directed, hand-computed vectors.
module tb_serial_add_sub_comp;

    localparam int unsigned N = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cbin;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic         flag;
    logic         aisbig;
    logic         bisbig;
    logic         equal;

    typedef struct packed {
        logic [N-1:0] result;
        logic         flag;
        logic         aisbig;
        logic         bisbig;
        logic         equal;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    serial_add_sub_comp #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .cbin      (cbin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag      (flag),
        .aisbig    (aisbig),
        .bisbig    (bisbig),
        .equal     (equal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [N-1:0] r, input logic f,
                                input logic ag, input logic bg, input logic eq);
        exp_t e;
        e.result = r;
        e.flag   = f;
        e.aisbig = ag;
        e.bisbig = bg;
        e.equal  = eq;
        return e;
    endfunction

    // Monitor: compare each handshaken result against the head of the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("result", 32'(result), 32'(e.result));
                    check("flag",   32'(flag),   32'(e.flag));
                    check("aisbig", 32'(aisbig), 32'(e.aisbig));
                    check("bisbig", 32'(bisbig), 32'(e.bisbig));
                    check("equal",  32'(equal),  32'(e.equal));
                end
            end
        end
    end

    // Present a command, wait for acceptance, push expectation, then scramble inputs
    task automatic issue(input logic [1:0] t_op, input logic [N-1:0] t_a,
                         input logic [N-1:0] t_b, input logic t_c, input exp_t e);
        int k;
        @(negedge clk);
        in_valid = 1'b1;
        op       = t_op;
        a        = t_a;
        b        = t_b;
        cbin     = t_c;
        k = 0;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        exp_q.push_back(e);
        #1;
        // Operands changing after acceptance must not matter
        op   = ~t_op;
        a    = ~t_a;
        b    = ~t_b;
        cbin = ~t_c;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Count edges from the accepting edge (counted as 1) until out_valid is seen
    task automatic wait_valid();
        int edges;
        edges = 2;
        while (!out_valid && edges < 30) begin
            @(posedge clk);
            #1;
            if (!out_valid) edges++;
        end
        check("latency_edges", 32'(edges), 32'(N + 1));
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (out_valid && k < 30) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("return_idle", 32'(out_valid), 32'd0);
    endtask

    task automatic run_op(input logic [1:0] t_op, input logic [N-1:0] t_a,
                          input logic [N-1:0] t_b, input logic t_c, input exp_t e);
        issue(t_op, t_a, t_b, t_c, e);
        wait_valid();
        wait_idle();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "simulation timeout");
    end

    initial begin : driver
        logic [N-1:0] snap_r;
        logic         snap_f;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = 2'b00;
        a         = '0;
        b         = '0;
        cbin      = 1'b0;
        out_ready = 1'b1;

        // Reset state
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_result",    32'(result),    32'd0);
        check("rst_flags",     32'({flag, aisbig, bisbig, equal}), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", 32'(in_ready), 32'd1);

        // Add 9+8: wraps to 1 with carry
        run_op(2'b00, 4'd9, 4'd8, 1'b0, mk(4'd1, 1'b1, 1'b0, 1'b0, 1'b0));
        // Add 6+7+1 = 14, no carry
        run_op(2'b00, 4'd6, 4'd7, 1'b1, mk(4'd14, 1'b0, 1'b0, 1'b0, 1'b0));
        // Subtract
        run_op(2'b01, 4'd3, 4'd5, 1'b0, mk(4'd14, 1'b1, 1'b0, 1'b0, 1'b0));
        run_op(2'b01, 4'd7, 4'd2, 1'b1, mk(4'd4,  1'b0, 1'b0, 1'b0, 1'b0));
        run_op(2'b01, 4'd0, 4'd0, 1'b1, mk(4'd15, 1'b1, 1'b0, 1'b0, 1'b0));
        // Compare
        run_op(2'b10, 4'd10, 4'd10, 1'b1, mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b1));
        run_op(2'b10, 4'd12, 4'd3,  1'b0, mk(4'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        run_op(2'b10, 4'd4,  4'd11, 1'b0, mk(4'd0, 1'b0, 1'b0, 1'b1, 1'b0));
        run_op(2'b10, 4'd8,  4'd7,  1'b0, mk(4'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        // Reserved op: all-zero outputs
        run_op(2'b11, 4'd5, 4'd6, 1'b1, mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0));

        // Backpressure: hold out_ready low for 3 cycles in DONE
        @(negedge clk);
        out_ready = 1'b0;
        issue(2'b00, 4'd6, 4'd7, 1'b1, mk(4'd14, 1'b0, 1'b0, 1'b0, 1'b0));
        wait_valid();
        snap_r = result;
        snap_f = flag;
        check("bp_snap_result", 32'(snap_r), 32'd14);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready",  32'(in_ready),  32'd0);
            check("bp_result",    32'(result),    32'(snap_r));
            check("bp_flag",      32'(flag),      32'(snap_f));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready),  32'd1);

        // Leave nonzero outputs behind, then abort a run with reset
        run_op(2'b01, 4'd3, 4'd5, 1'b0, mk(4'd14, 1'b1, 1'b0, 1'b0, 1'b0));
        issue(2'b00, 4'd5, 4'd6, 1'b0, mk(4'd11, 1'b0, 1'b0, 1'b0, 1'b0));
        // issue returned at the negedge after accept; bits 0 and 1 finish on the next two edges
        @(posedge clk);
        @(posedge clk);
        #1;
        check("run_holds_result", 32'(result), 32'd14);
        check("run_in_ready",     32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        void'(exp_q.pop_back());
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_result",    32'(result),    32'd0);
        check("abort_flags",     32'({flag, aisbig, bisbig, equal}), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("abort_ready_after", 32'(in_ready), 32'd1);
        run_op(2'b00, 4'd15, 4'd0, 1'b1, mk(4'd0, 1'b1, 1'b0, 1'b0, 1'b0));

        repeat (3) @(posedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
